binary_to_bcd_seq: RTL and testbench

Iterative, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
It replaces the combinational 16-bit/4-digit converter on the display and readout path, where timing closure matters more than latency.
It has generic input width and digit count, a start/ready/done handshake, held result registers and overflow saturation.

---
 rtl/binary_to_bcd_seq.sv | 68 ++++++
 tb/tb_binary_to_bcd_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: one-bit-per-clock double-dabble converter; in: clk, rst, start, binary; out: ready, done, bcd, overflow
module binary_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_sh;
  logic [BW-1:0]    r_acc;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_ovf_out;
  logic             r_done;
  logic [BW-1:0]    w_adj;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? r_acc[4*g +: 4] + 4'd3 : r_acc[4*g +: 4];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_sh    <= binary;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
        r_cnt   <= CW'(BIN_W);
        r_state <= S_SHIFT;
      end else if (r_state == S_SHIFT) begin
        r_acc <= {w_adj[BW-2:0], r_sh[BIN_W-1]};
        r_sh  <= r_sh << 1;
        r_ovf <= r_ovf | w_adj[BW-1];
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_state <= S_DONE;
      end else if (r_state == S_DONE) begin
        r_bcd     <= r_ovf ? {DIGITS{4'h9}} : r_acc;
        r_ovf_out <= r_ovf;
        r_done    <= 1'b1;
        r_state   <= S_IDLE;
      end
    end
  end
  assign ready    = (r_state == S_IDLE);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf_out;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: scoreboard bench for the 5-digit and 4-digit converter builds
module tb_binary_to_bcd_seq;
  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;
  logic        clk;
  logic        rst;
  logic        start5, start4;
  logic [15:0] binary5, binary4;
  logic        ready5, ready4, done5, done4, ovf5, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q5[$];
  exp_t        q4[$];
  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .binary(binary5),
    .ready(ready5), .done(done5), .bcd(bcd5), .overflow(ovf5)
  );
  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .binary(binary4),
    .ready(ready4), .done(done4), .bcd(bcd4), .overflow(ovf4)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done5) begin
      if (q5.size() == 0) chk("dut5_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q5.pop_front();
        chk("dut5_bcd", 32'(bcd5), 32'(e.bcd));
        chk("dut5_ovf", 32'(ovf5), 32'(e.ovf));
        chk("dut5_latency", 32'(cyc - e.acc), 32'd17);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4) begin
      if (q4.size() == 0) chk("dut4_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("dut4_bcd", 32'(bcd4), 32'(e.bcd[15:0]));
        chk("dut4_ovf", 32'(ovf4), 32'(e.ovf));
        chk("dut4_latency", 32'(cyc - e.acc), 32'd17);
      end
    end
  end
  // Issue one start at a negedge; the next posedge accepts it.
  task automatic go(input bit sel, input logic [15:0] b, input logic [19:0] eb, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    e.acc = cyc + 1;
    if (sel) begin
      binary4 = b;
      start4  = 1'b1;
      q4.push_back(e);
    end else begin
      binary5 = b;
      start5  = 1'b1;
      q5.push_back(e);
    end
    @(negedge clk);
    start4 = 1'b0;
    start5 = 1'b0;
  endtask
  task automatic wait_empty();
    int n = 0;
    while ((q5.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q5.size() + q4.size()), 32'd0);
  endtask
  logic [15:0] vin [9]  = '{16'd5, 16'd12, 16'd99, 16'd123, 16'd256, 16'd1023, 16'd4096, 16'd9999, 16'd65535};
  logic [19:0] vexp [9] = '{20'h00005, 20'h00012, 20'h00099, 20'h00123, 20'h00256, 20'h01023, 20'h04096, 20'h09999, 20'h65535};
  logic [15:0] v4in [4]  = '{16'd9999, 16'd10000, 16'd65535, 16'd42};
  logic [19:0] v4exp [4] = '{20'h09999, 20'h09999, 20'h09999, 20'h00042};
  logic        v4ovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  initial begin
    exp_t e;
    int a;
    rst = 1'b1;
    start5 = 1'b0; start4 = 1'b0;
    binary5 = '0; binary4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready5), 32'd1);
    chk("reset_done", 32'(done5), 32'd0);
    chk("reset_bcd", 32'(bcd5), 32'd0);
    chk("reset_ovf", 32'(ovf5), 32'd0);
    chk("reset_ready4", 32'(ready4), 32'd1);
    go(1'b0, 16'd0, 20'h00000, 1'b0);
    wait_empty();
    for (int i = 0; i < 9; i++) begin
      go(1'b0, vin[i], vexp[i], 1'b0);
      wait_empty();
    end
    for (int i = 0; i < 4; i++) begin
      go(1'b1, v4in[i], v4exp[i], v4ovf[i]);
      wait_empty();
    end
    go(1'b0, 16'd1234, 20'h01234, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_ready", 32'(ready5), 32'd0);
    binary5 = 16'd777;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    chk("busy_ready_after", 32'(ready5), 32'd0);
    wait_empty();
    repeat (20) @(negedge clk);
    binary5 = 16'd321;
    start5 = 1'b1;
    a = cyc + 1;
    e.bcd = 20'h00321; e.ovf = 1'b0; e.acc = a;
    q5.push_back(e);
    while (cyc < a + 17) @(negedge clk);
    binary5 = 16'd654;
    e.bcd = 20'h00654; e.ovf = 1'b0; e.acc = cyc + 1;
    q5.push_back(e);
    @(negedge clk);
    start5 = 1'b0;
    wait_empty();
    go(1'b0, 16'd4321, 20'h04321, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    q5.delete();
    chk("abort_ready", 32'(ready5), 32'd1);
    chk("abort_done", 32'(done5), 32'd0);
    chk("abort_bcd", 32'(bcd5), 32'd0);
    chk("abort_ovf", 32'(ovf5), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    go(1'b0, 16'd50, 20'h00050, 1'b0);
    wait_empty();
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
